// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter
// Purpose  : Common-data-bus arbiter. Three per-source completion FIFOs
//            (ALU, load, store) feed one registered broadcast bus, granted
//            round-robin at one result per cycle. clear_all discards all
//            queued results; rdy_in low freezes every piece of state.
// Ports    : clk_in / rst_in (async, active-high) / rdy_in (global pause)
//            clear_all                      - mispredict flush
//            alu_* / ld_* / st_*            - valid/value/dest in, ready out
//            cdb_valid/value/dest/src       - registered broadcast bus
//            busy                           - any entry queued or on the bus
// Revision : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
  parameter int ROB_ID_BIT = 4,
  parameter int QDEPTH     = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  clear_all,
  input  logic                  alu_valid,
  input  logic [31:0]           alu_value,
  input  logic [ROB_ID_BIT-1:0] alu_dest,
  output logic                  alu_ready,
  input  logic                  ld_valid,
  input  logic [31:0]           ld_value,
  input  logic [ROB_ID_BIT-1:0] ld_dest,
  output logic                  ld_ready,
  input  logic                  st_valid,
  input  logic [ROB_ID_BIT-1:0] st_dest,
  output logic                  st_ready,
  output logic                  cdb_valid,
  output logic [31:0]           cdb_value,
  output logic [ROB_ID_BIT-1:0] cdb_dest,
  output logic [1:0]            cdb_src,
  output logic                  busy
);

  localparam int                 c_PTR_W = $clog2(QDEPTH);
  localparam int                 c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(QDEPTH);
  localparam logic [c_PTR_W-1:0] c_PTR_1 = c_PTR_W'(1);

  // Per-source bookkeeping; index 0 = ALU, 1 = load, 2 = store.
  logic [c_PTR_W-1:0]    head_q [3];
  logic [c_PTR_W-1:0]    head_d [3];
  logic [c_PTR_W-1:0]    tail_q [3];
  logic [c_PTR_W-1:0]    tail_d [3];
  logic [c_CNT_W-1:0]    cnt_q  [3];
  logic [c_CNT_W-1:0]    cnt_d  [3];
  logic [1:0]            rr_q, rr_d;
  logic                  cdb_valid_q, cdb_valid_d;
  logic [31:0]           cdb_value_q, cdb_value_d;
  logic [ROB_ID_BIT-1:0] cdb_dest_q, cdb_dest_d;
  logic [1:0]            cdb_src_q, cdb_src_d;

  logic [2:0]            w_in_valid;
  logic [31:0]           w_in_value [3];
  logic [ROB_ID_BIT-1:0] w_in_dest  [3];
  logic [31:0]           w_head_value [3];
  logic [ROB_ID_BIT-1:0] w_head_dest  [3];
  logic [2:0]            w_ready;
  logic [2:0]            w_push;
  logic [2:0]            w_pop;
  logic                  w_adv;
  logic                  w_grant;
  logic [1:0]            w_win;
  logic [2:0]            w_sum;

  assign w_in_valid    = {st_valid, ld_valid, alu_valid};
  assign w_in_value[0] = alu_value;
  assign w_in_value[1] = ld_value;
  assign w_in_value[2] = 32'd0;        // stores carry no data
  assign w_in_dest[0]  = alu_dest;
  assign w_in_dest[1]  = ld_dest;
  assign w_in_dest[2]  = st_dest;

  // Normal push/pop activity happens only when running and not flushing.
  assign w_adv = rdy_in && !clear_all;

  for (genvar g = 0; g < 3; g++) begin : g_src
    logic [31:0]           mem_value_q [QDEPTH];
    logic [ROB_ID_BIT-1:0] mem_dest_q  [QDEPTH];

    // Ready looks only at the registered count, never at a same-cycle pop.
    assign w_ready[g] = rdy_in && (cnt_q[g] < c_FULL);
    assign w_push[g]  = w_adv && w_in_valid[g] && w_ready[g];
    assign w_pop[g]   = w_adv && w_grant && (w_win == 2'(g));

    assign w_head_value[g] = mem_value_q[head_q[g]];
    assign w_head_dest[g]  = mem_dest_q[head_q[g]];

    // Payload storage needs no reset: count gates every read.
    always_ff @(posedge clk_in) begin
      if (w_push[g]) begin
        mem_value_q[tail_q[g]] <= w_in_value[g];
        mem_dest_q[tail_q[g]]  <= w_in_dest[g];
      end
    end
  end

  // Round-robin search; walking k downward lets the lowest offset win.
  always_comb begin
    w_grant = 1'b0;
    w_win   = 2'd0;
    w_sum   = 3'd0;
    for (int k = 2; k >= 0; k--) begin
      w_sum = {1'b0, rr_q} + 3'(k);
      if (w_sum >= 3'd3) begin
        w_sum = w_sum - 3'd3;
      end
      if (cnt_q[w_sum[1:0]] != '0) begin
        w_grant = 1'b1;
        w_win   = w_sum[1:0];
      end
    end
  end

  always_comb begin
    rr_d        = rr_q;
    cdb_valid_d = cdb_valid_q;
    cdb_value_d = cdb_value_q;
    cdb_dest_d  = cdb_dest_q;
    cdb_src_d   = cdb_src_q;
    for (int s = 0; s < 3; s++) begin
      head_d[s] = head_q[s];
      tail_d[s] = tail_q[s];
      cnt_d[s]  = cnt_q[s];
    end
    if (rdy_in) begin
      if (clear_all) begin
        rr_d        = 2'd0;
        cdb_valid_d = 1'b0;
        for (int s = 0; s < 3; s++) begin
          head_d[s] = '0;
          tail_d[s] = '0;
          cnt_d[s]  = '0;
        end
      end else begin
        cdb_valid_d = w_grant;
        if (w_grant) begin
          cdb_value_d = w_head_value[w_win];
          cdb_dest_d  = w_head_dest[w_win];
          cdb_src_d   = w_win;
          rr_d        = (w_win == 2'd2) ? 2'd0 : w_win + 2'd1;
        end
        for (int s = 0; s < 3; s++) begin
          if (w_push[s]) begin
            tail_d[s] = tail_q[s] + c_PTR_1;
          end
          if (w_pop[s]) begin
            head_d[s] = head_q[s] + c_PTR_1;
          end
          cnt_d[s] = cnt_q[s] + c_CNT_W'(w_push[s]) - c_CNT_W'(w_pop[s]);
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rr_q        <= 2'd0;
      cdb_valid_q <= 1'b0;
      cdb_value_q <= 32'd0;
      cdb_dest_q  <= '0;
      cdb_src_q   <= 2'd0;
      for (int s = 0; s < 3; s++) begin
        head_q[s] <= '0;
        tail_q[s] <= '0;
        cnt_q[s]  <= '0;
      end
    end else begin
      rr_q        <= rr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_value_q <= cdb_value_d;
      cdb_dest_q  <= cdb_dest_d;
      cdb_src_q   <= cdb_src_d;
      for (int s = 0; s < 3; s++) begin
        head_q[s] <= head_d[s];
        tail_q[s] <= tail_d[s];
        cnt_q[s]  <= cnt_d[s];
      end
    end
  end

  assign alu_ready = w_ready[0];
  assign ld_ready  = w_ready[1];
  assign st_ready  = w_ready[2];
  assign cdb_valid = cdb_valid_q;
  assign cdb_value = cdb_value_q;
  assign cdb_dest  = cdb_dest_q;
  assign cdb_src   = cdb_src_q;
  assign busy      = (cnt_q[0] != '0) || (cnt_q[1] != '0) ||
                     (cnt_q[2] != '0) || cdb_valid_q;

endmodule
`default_nettype wire
